ttt_game_ctrl: RTL and testbench

- Game controller for the Tic Tac Toe VGA screen.
- Tracks the mouse cursor from PS/2 packets and maps it to a board cell or an on-screen label.
- Sequences play: place mark, turn change, win/draw check, score keeping, Match Restart / Erase Score actions.
- Outputs (board, cursor, scores, state, label select) feed the text painter combinationally; no pixel logic here.

---
 rtl/ttt_pkg.sv | 53 +++++
 rtl/ttt_win_check.sv | 39 +++
 rtl/ttt_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_pkg
//  Brief    : Shared encodings, winning-line table and screen geometry for the
//             Tic Tac Toe controller and text painter.
//  Revision : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_DRAW  = 2'd3
    } state_e;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    // Rows 0-2, columns 3-5, then the two diagonals; index order sets priority.
    localparam logic [3:0] LINE_TBL [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [9:0] BOARD_X0  = 10'd150;
    localparam logic [9:0] BOARD_Y0  = 10'd100;
    localparam logic [9:0] CELL      = 10'd80;
    localparam logic [9:0] BOARD_X1  = BOARD_X0 + CELL + CELL + CELL;
    localparam logic [9:0] BOARD_Y1  = BOARD_Y0 + CELL + CELL + CELL;
    localparam logic [9:0] CUR_SIZE  = 10'd15;
    localparam logic [9:0] H_RES     = 10'd640;
    localparam logic [9:0] V_RES     = 10'd480;
    localparam logic [9:0] CUR_X_MAX = H_RES - CUR_SIZE;
    localparam logic [9:0] CUR_Y_MAX = V_RES - CUR_SIZE;
    localparam logic [9:0] CUR_INIT  = 10'd245;
    localparam logic [9:0] BTN_Y0    = 10'd416;
    localparam logic [9:0] BTN_Y1    = 10'd447;
    localparam logic [9:0] RST_X0    = 10'd128;
    localparam logic [9:0] RST_X1    = 10'd335;
    localparam logic [9:0] ERS_X0    = 10'd352;
    localparam logic [9:0] ERS_X1    = 10'd527;
    localparam logic [3:0] SCORE_MAX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/ttt_win_check.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_win_check
//  Brief    : Combinational three-in-a-row and board-full detection for one
//             player mark.
//  Revision : 1.0 - initial release
// ============================================================================
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] board_i,
    input  logic [1:0]  mark_i,
    output logic        win_o,
    output logic [2:0]  line_o,
    output logic        full_o
);

    // Scan lines from highest to lowest index so the lowest match wins.
    always_comb begin
        win_o  = 1'b0;
        line_o = 3'd0;
        full_o = 1'b1;
        for (int l = 7; l >= 0; l--) begin
            if (board_i[{LINE_TBL[l][0], 1'b0} +: 2] == mark_i &&
                board_i[{LINE_TBL[l][1], 1'b0} +: 2] == mark_i &&
                board_i[{LINE_TBL[l][2], 1'b0} +: 2] == mark_i) begin
                win_o  = 1'b1;
                line_o = 3'(l);
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (board_i[k*2 +: 2] == CELL_EMPTY) begin
                full_o = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_game_ctrl
//  Brief    : Mouse cursor tracking, hit decode and play sequencing for the
//             Tic Tac Toe screen (board, turn, win/draw, scores, labels).
//  Revision : 1.0 - initial release
// ============================================================================
module ttt_game_ctrl
    import ttt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m_done_tick,
    input  logic [8:0]  xm,
    input  logic [8:0]  ym,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [9:0]  cur_x,
    output logic [9:0]  cur_y,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic [3:0]  score_x,
    output logic [3:0]  score_o,
    output logic        sel
);

    state_e      state_q, state_d;
    logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d, sel_q, sel_d;
    logic [1:0]  winner_q, winner_d;
    logic [2:0]  win_line_q, win_line_d;
    logic [3:0]  score_x_q, score_x_d, score_o_q, score_o_d;
    logic        btn_l_q, btn_r_q;

    logic signed [11:0] x_sum, y_sum;
    logic [9:0]  x_clamped, y_clamped;
    logic        in_board, hit_rst, hit_ers, cell_empty;
    logic [1:0]  row, col, mover_mark;
    logic [3:0]  cell_idx;
    logic        lclick, rclick;
    logic        chk_win, chk_full;
    logic [2:0]  chk_line;

    // Cursor motion in signed arithmetic; screen y grows downward, mouse y up.
    assign x_sum = $signed({2'b00, cur_x_q}) + $signed({{3{xm[8]}}, xm});
    assign y_sum = $signed({2'b00, cur_y_q}) - $signed({{3{ym[8]}}, ym});
    assign x_clamped = (x_sum < 12'sd0) ? 10'd0 :
                       (x_sum > $signed({2'b00, CUR_X_MAX})) ? CUR_X_MAX : x_sum[9:0];
    assign y_clamped = (y_sum < 12'sd0) ? 10'd0 :
                       (y_sum > $signed({2'b00, CUR_Y_MAX})) ? CUR_Y_MAX : y_sum[9:0];

    // Hit decode from the registered cursor position.
    assign in_board = (cur_x_q >= BOARD_X0) && (cur_x_q < BOARD_X1) &&
                      (cur_y_q >= BOARD_Y0) && (cur_y_q < BOARD_Y1);
    assign col = (cur_x_q < BOARD_X0 + CELL) ? 2'd0 :
                 (cur_x_q < BOARD_X0 + CELL + CELL) ? 2'd1 : 2'd2;
    assign row = (cur_y_q < BOARD_Y0 + CELL) ? 2'd0 :
                 (cur_y_q < BOARD_Y0 + CELL + CELL) ? 2'd1 : 2'd2;
    assign cell_idx   = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
    assign cell_empty = (board_q[{cell_idx, 1'b0} +: 2] == CELL_EMPTY);
    assign hit_rst = (cur_y_q >= BTN_Y0) && (cur_y_q <= BTN_Y1) &&
                     (cur_x_q >= RST_X0) && (cur_x_q <= RST_X1);
    assign hit_ers = (cur_y_q >= BTN_Y0) && (cur_y_q <= BTN_Y1) &&
                     (cur_x_q >= ERS_X0) && (cur_x_q <= ERS_X1);

    // A left edge takes precedence; a simultaneous right edge is dropped.
    assign lclick = btn_left & ~btn_l_q;
    assign rclick = btn_right & ~btn_r_q & ~lclick;

    // Turn has already toggled when CHECK runs, so the mover is the other side.
    assign mover_mark = turn_q ? CELL_X : CELL_O;

    ttt_win_check u_win_check (
        .board_i (board_q),
        .mark_i  (mover_mark),
        .win_o   (chk_win),
        .line_o  (chk_line),
        .full_o  (chk_full)
    );

    // Next-state logic: cursor, click actions and the CHECK resolution.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        board_d    = board_q;
        turn_d     = turn_q;
        sel_d      = sel_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        score_x_d  = score_x_q;
        score_o_d  = score_o_q;

        if (m_done_tick) begin
            cur_x_d = x_clamped;
            cur_y_d = y_clamped;
        end

        if (state_q == ST_CHECK) begin
            if (chk_win) begin
                state_d    = ST_WIN;
                winner_d   = mover_mark;
                win_line_d = chk_line;
                if (mover_mark == CELL_X) begin
                    if (score_x_q != SCORE_MAX) score_x_d = score_x_q + 4'd1;
                end else begin
                    if (score_o_q != SCORE_MAX) score_o_d = score_o_q + 4'd1;
                end
            end else if (chk_full) begin
                state_d = ST_DRAW;
            end else begin
                state_d = ST_PLAY;
            end
        end else if ((lclick && (hit_rst || hit_ers)) || rclick) begin
            // Restart / Erase share the clear; Erase also zeroes the scores.
            board_d    = 18'd0;
            turn_d     = 1'b0;
            winner_d   = CELL_EMPTY;
            win_line_d = 3'd0;
            state_d    = ST_PLAY;
            sel_d      = lclick ? hit_ers : ~sel_q;
            if ((lclick && hit_ers) || (rclick && !sel_q)) begin
                score_x_d = 4'd0;
                score_o_d = 4'd0;
            end
        end else if (lclick && state_q == ST_PLAY && in_board && cell_empty) begin
            board_d[{cell_idx, 1'b0} +: 2] = turn_q ? CELL_O : CELL_X;
            turn_d  = ~turn_q;
            state_d = ST_CHECK;
        end
    end

    // State registers; button history resets high so a held button is not a click.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_PLAY;
            cur_x_q    <= CUR_INIT;
            cur_y_q    <= CUR_INIT;
            board_q    <= 18'd0;
            turn_q     <= 1'b0;
            sel_q      <= 1'b0;
            winner_q   <= CELL_EMPTY;
            win_line_q <= 3'd0;
            score_x_q  <= 4'd0;
            score_o_q  <= 4'd0;
            btn_l_q    <= 1'b1;
            btn_r_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            sel_q      <= sel_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            score_x_q  <= score_x_d;
            score_o_q  <= score_o_d;
            btn_l_q    <= btn_left;
            btn_r_q    <= btn_right;
        end
    end

    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign board      = board_q;
    assign turn       = turn_q;
    assign game_state = state_q;
    assign winner     = winner_q;
    assign win_line   = win_line_q;
    assign score_x    = score_x_q;
    assign score_o    = score_o_q;
    assign sel        = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ttt_game_ctrl
//  Brief    : Directed self-checking bench for ttt_game_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        reset, m_done_tick, btn_left, btn_right;
    logic [8:0]  xm, ym;
    logic [9:0]  cur_x, cur_y;
    logic [17:0] board;
    logic        turn, sel;
    logic [1:0]  game_state, winner;
    logic [2:0]  win_line;
    logic [3:0]  score_x, score_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_x = 245;
    int exp_y = 245;

    always #5 clk = ~clk;

    ttt_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .m_done_tick (m_done_tick),
        .xm          (xm),
        .ym          (ym),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .board       (board),
        .turn        (turn),
        .game_state  (game_state),
        .winner      (winner),
        .win_line    (win_line),
        .score_x     (score_x),
        .score_o     (score_o),
        .sel         (sel)
    );

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One mouse packet; dy is in screen direction (down positive).
    task automatic pkt(input int dx, input int dy);
        int ny;
        ny = -dy;
        xm = dx[8:0];
        ym = ny[8:0];
        m_done_tick = 1'b1;
        tick();
        m_done_tick = 1'b0;
        exp_x = exp_x + dx;
        exp_y = exp_y + dy;
        if (exp_x < 0) exp_x = 0;
        if (exp_x > 625) exp_x = 625;
        if (exp_y < 0) exp_y = 0;
        if (exp_y > 465) exp_y = 465;
    endtask

    task automatic move_to(input int x, input int y);
        int dx, dy;
        for (int n = 0; n < 20 && (exp_x != x || exp_y != y); n++) begin
            dx = x - exp_x;
            dy = y - exp_y;
            if (dx > 255) dx = 255;
            if (dx < -256) dx = -256;
            if (dy > 255) dy = 255;
            if (dy < -255) dy = -255;
            pkt(dx, dy);
        end
    endtask

    task automatic click_left();
        btn_left = 1'b1;
        tick();
        btn_left = 1'b0;
        tick();
        tick();
    endtask

    task automatic click_right();
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        tick();
        tick();
    endtask

    task automatic click_cell(input int k);
        move_to(190 + 80 * (k % 3), 140 + 80 * (k / 3));
        click_left();
    endtask

    task automatic check_reset_values(input string pfx);
        check_value({pfx, "_cur_x"},   32'(cur_x), 32'd245);
        check_value({pfx, "_cur_y"},   32'(cur_y), 32'd245);
        check_value({pfx, "_board"},   32'(board), 32'd0);
        check_value({pfx, "_turn"},    32'(turn), 32'd0);
        check_value({pfx, "_state"},   32'(game_state), 32'd0);
        check_value({pfx, "_winner"},  32'(winner), 32'd0);
        check_value({pfx, "_winline"}, 32'(win_line), 32'd0);
        check_value({pfx, "_score_x"}, 32'(score_x), 32'd0);
        check_value({pfx, "_score_o"}, 32'(score_o), 32'd0);
        check_value({pfx, "_sel"},     32'(sel), 32'd0);
    endtask

    initial begin
        reset = 1'b1; m_done_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        xm = 9'd0; ym = 9'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_values("rst");

        // Cursor clamp at the right/bottom and then the left edge.
        for (int i = 0; i < 5; i++) pkt(255, 255);
        check_value("clamp_x_max", 32'(cur_x), 32'd625);
        check_value("clamp_y_max", 32'(cur_y), 32'd465);
        for (int i = 0; i < 3; i++) pkt(-256, 0);
        check_value("clamp_x_min", 32'(cur_x), 32'd0);
        check_value("clamp_y_hold", 32'(cur_y), 32'd465);

        // X takes the top row: cells 0,3,1,4,2.
        move_to(190, 140);
        check_value("move_x", 32'(cur_x), 32'd190);
        check_value("move_y", 32'(cur_y), 32'd140);
        btn_left = 1'b1;
        tick();
        check_value("first_state_check", 32'(game_state), 32'd1);
        check_value("first_board", 32'(board), 32'h1);
        check_value("first_turn", 32'(turn), 32'd1);
        btn_left = 1'b0;
        tick();
        check_value("first_state_play", 32'(game_state), 32'd0);
        tick();
        click_cell(3);
        click_cell(1);
        click_cell(4);
        click_cell(2);
        check_value("win_state", 32'(game_state), 32'd2);
        check_value("win_winner", 32'(winner), 32'd1);
        check_value("win_line", 32'(win_line), 32'd0);
        check_value("win_score_x", 32'(score_x), 32'd1);
        check_value("win_score_o", 32'(score_o), 32'd0);
        check_value("win_board", 32'(board), 32'(18'b00_00_00_00_10_10_01_01_01));

        // Cell click after a win is ignored.
        click_cell(5);
        check_value("won_cell_board", 32'(board), 32'(18'b00_00_00_00_10_10_01_01_01));
        check_value("won_cell_state", 32'(game_state), 32'd2);

        // Match Restart keeps the score.
        move_to(200, 430);
        click_left();
        check_value("restart_board", 32'(board), 32'd0);
        check_value("restart_turn", 32'(turn), 32'd0);
        check_value("restart_state", 32'(game_state), 32'd0);
        check_value("restart_winner", 32'(winner), 32'd0);
        check_value("restart_score_x", 32'(score_x), 32'd1);
        check_value("restart_sel", 32'(sel), 32'd0);

        // Draw game with occupied and off-board clicks mixed in.
        click_cell(0);
        click_cell(0);
        check_value("occupied_board", 32'(board), 32'h1);
        check_value("occupied_turn", 32'(turn), 32'd1);
        check_value("occupied_state", 32'(game_state), 32'd0);
        move_to(50, 50);
        click_left();
        check_value("offboard_board", 32'(board), 32'h1);
        check_value("offboard_turn", 32'(turn), 32'd1);
        click_cell(1);
        click_cell(2);
        click_cell(4);
        click_cell(3);
        click_cell(5);
        click_cell(7);
        click_cell(6);
        // Last move with both buttons: left wins, right edge dropped.
        move_to(350, 300);
        btn_left = 1'b1;
        btn_right = 1'b1;
        tick();
        btn_left = 1'b0;
        btn_right = 1'b0;
        tick();
        tick();
        check_value("draw_board", 32'(board), 32'(18'b01_01_10_10_10_01_01_10_01));
        check_value("draw_state", 32'(game_state), 32'd3);
        check_value("draw_winner", 32'(winner), 32'd0);
        check_value("draw_score_x", 32'(score_x), 32'd1);
        check_value("draw_score_o", 32'(score_o), 32'd0);
        check_value("draw_sel", 32'(sel), 32'd0);

        // Erase Score label.
        move_to(400, 430);
        click_left();
        check_value("erase_score_x", 32'(score_x), 32'd0);
        check_value("erase_sel", 32'(sel), 32'd1);
        check_value("erase_board", 32'(board), 32'd0);
        check_value("erase_state", 32'(game_state), 32'd0);

        // Right click toggles sel (1 -> 0) and performs Restart.
        click_cell(4);
        check_value("pre_right_board", 32'(board), 32'h100);
        click_right();
        check_value("right_sel", 32'(sel), 32'd0);
        check_value("right_board", 32'(board), 32'd0);
        check_value("right_turn", 32'(turn), 32'd0);

        // Button held through reset makes no click (cursor lands on cell 4).
        btn_left = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_x = 245;
        exp_y = 245;
        tick();
        tick();
        check_value("held_board", 32'(board), 32'd0);
        check_value("held_state", 32'(game_state), 32'd0);
        btn_left = 1'b0;
        tick();

        // Reset asserted in the CHECK cycle of a winning move.
        click_cell(0);
        click_cell(3);
        click_cell(1);
        click_cell(4);
        move_to(350, 140);
        btn_left = 1'b1;
        tick();
        check_value("pre_rst_state", 32'(game_state), 32'd1);
        reset = 1'b1;
        btn_left = 1'b0;
        tick();
        reset = 1'b0;
        exp_x = 245;
        exp_y = 245;
        check_reset_values("chkrst");
        tick();
        check_value("chkrst_after_score_x", 32'(score_x), 32'd0);
        check_value("chkrst_after_state", 32'(game_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
